memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.
- Consumes the execute stage's ALU result, store data and control bits.
- Performs load/store against an internal word-organised data memory with byte lanes.
- Registers the writeback bundle: data, destination register, write enable and valid flag.

Parameters:
- DEPTH, 1024, number of 32-bit words in the data memory.
- ADDR_BITS, 10, word-index width; must equal log2(DEPTH).

Ports:
- ms_clk  input  1  stage clock.
- ms_rst  input  1  reset; asynchronous, active-low.
- ms_i_ce  input  1  valid instruction from execute.
- ms_i_opcode  input  `OPCODE_WIDTH  MIPS opcode of the instruction.
- ms_i_alu_value  input  `DWIDTH  ALU result; the byte address for loads and stores.
- ms_i_data_rt  input  `DWIDTH  store data (rt).
- ms_i_memwrite  input  1  store instruction.
- ms_i_memtoreg  input  1  load instruction; writeback source is memory.
- ms_i_reg_wr  input  1  instruction writes the register file.
- ms_i_addr_rd  input  `AWIDTH  destination register.
- ms_o_ce  output  1  valid writeback bundle.
- ms_o_data_rd  output  `DWIDTH  writeback data.
- ms_o_addr_rd  output  `AWIDTH  destination register.
- ms_o_reg_wr  output  1  register-file write enable.
- ms_o_misalign  output  1  one-cycle pulse flagging a misaligned access.

Behaviour:
- Reset (ms_rst=0, asynchronous):
  - ms_o_ce, ms_o_data_rd, ms_o_addr_rd, ms_o_reg_wr and ms_o_misalign all go to 0 immediately.
  - Memory contents are not reset; simulation initialises them to 0.
  - A store presented on the edge where reset is low is dropped.
- Latency: 1 cycle. An instruction presented at edge N appears on the outputs after edge N.
- Address handling:
  - Word index = ms_i_alu_value[ADDR_BITS+1:2]; upper bits are ignored, so the index wraps modulo DEPTH.
  - Byte lane = ms_i_alu_value[1:0].
  - Little-endian: lane 0 = bits 7:0.
- Opcodes: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B.
- Alignment rules:
  - Halfword accesses require addr[0]=0.
  - Word accesses require addr[1:0]=0.
  - Byte accesses are always aligned.
- Store, when ms_i_ce=1, ms_i_memwrite=1 and the access is aligned:
  - sw writes 4 lanes; sh writes lanes {addr[1],1'b0}+0..1 with rt[15:0]; sb writes lane addr[1:0] with rt[7:0].
  - Other lanes are untouched.
  - The write completes at the edge.
  - Stores force ms_o_reg_wr=0.
- Load, when ms_i_ce=1 and ms_i_memtoreg=1:
  - The word is read at the edge, using the same-edge pre-write value.
  - The selected lane(s) are extracted.
  - lb and lh sign-extend; lbu and lhu zero-extend; lw passes the word through.
  - A store at edge N followed by a load from the same address at edge N+1 returns the stored data. No bypass is needed.
- Non-memory instruction (memtoreg=0, memwrite=0): ms_o_data_rd = ms_i_alu_value, registered.
- Misaligned access:
  - The store is suppressed, or the load's ms_o_reg_wr is forced to 0.
  - ms_o_misalign=1 for exactly one cycle.
  - ms_o_ce=1 and ms_o_addr_rd is still passed through.
- ms_o_reg_wr = ms_i_ce & ms_i_reg_wr & ~memwrite & ~misalign, registered.
- Idle input (ms_i_ce=0):
  - Next cycle ms_o_ce=0, ms_o_reg_wr=0 and ms_o_misalign=0.
  - ms_o_data_rd and ms_o_addr_rd hold their previous values.
  - Memory is unchanged.
- Unknown opcode with memtoreg or memwrite set: treat as a word access.

Decomposition:
- Shared package/defines header:
  - Opcode constants (OP_LB … OP_SW), reusing the existing `DWIDTH, `AWIDTH and `OPCODE_WIDTH.
  - An access-size encoding (SZ_BYTE, SZ_HALF, SZ_WORD).
- One natural sub-module, `dmem`:
  - Synchronous single-port word RAM with a 4-bit byte-enable write and registered read data.
  - Parameterised by DEPTH.
- memory_stage itself holds:
  - Alignment check.
  - Byte-enable and store-data lane replication.
  - Load extract/extend.
  - The output pipeline register.

Test Plan:
1. Reset: hold ms_rst=0 with random inputs -> all outputs 0. Release, then ms_i_ce=0 -> ms_o_ce stays 0.
2. sw rt=0xDEADBEEF at addr 0x10, then lw at 0x10 with rd=5 on the next cycle -> one cycle after the lw: ms_o_data_rd=0xDEADBEEF, ms_o_addr_rd=5, ms_o_reg_wr=1, ms_o_ce=1. For the sw cycle, ms_o_reg_wr=0.
3. With 0xDEADBEEF stored at 0x10:
   - lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE.
   - lh 0x12 -> 0xFFFFDEAD; lhu 0x12 -> 0x0000DEAD.
   - lb 0x10 -> 0xFFFFFFEF.
4. sb rt=0x123456AA at 0x11, sh rt=0xCAFE7777 at 0x12, then lw 0x10 -> 0x7777AAEF.
5. ALU pass-through: memtoreg=0, memwrite=0, alu_value=0x00001234, reg_wr=1, rd=9 -> data_rd=0x1234, addr_rd=9, reg_wr=1. Wrap-around: sw at 0x1000 (DEPTH=1024) then lw at 0x0 -> the same data.
6. Misaligned cases:
   - lw at 0x12 -> misalign=1 for 1 cycle, reg_wr=0.
   - sw 0xFFFFFFFF at 0x11 -> misalign=1, then lw 0x10 -> unchanged value.
   - Assert ms_rst low on the same edge as an sw -> memory is unchanged.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared constants and helpers for the MEM stage: data/register/opcode widths,
// MIPS load/store opcodes and the access-size encoding.
`ifndef DWIDTH
`define DWIDTH 32
`endif
`ifndef AWIDTH
`define AWIDTH 5
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 6
`endif

package memory_stage_pkg;

  localparam int DWIDTH       = `DWIDTH;
  localparam int AWIDTH       = `AWIDTH;
  localparam int OPCODE_WIDTH = `OPCODE_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] OP_LB  = OPCODE_WIDTH'(6'h20);
  localparam logic [OPCODE_WIDTH-1:0] OP_LH  = OPCODE_WIDTH'(6'h21);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW  = OPCODE_WIDTH'(6'h23);
  localparam logic [OPCODE_WIDTH-1:0] OP_LBU = OPCODE_WIDTH'(6'h24);
  localparam logic [OPCODE_WIDTH-1:0] OP_LHU = OPCODE_WIDTH'(6'h25);
  localparam logic [OPCODE_WIDTH-1:0] OP_SB  = OPCODE_WIDTH'(6'h28);
  localparam logic [OPCODE_WIDTH-1:0] OP_SH  = OPCODE_WIDTH'(6'h29);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW  = OPCODE_WIDTH'(6'h2B);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Unknown opcodes fall through to a full-word access.
  function automatic size_e access_size(input logic [OPCODE_WIDTH-1:0] op);
    size_e sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
      default:              sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic is_signed_load(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] lane);
    logic mis;
    case (sz)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lane[0];
      default: mis = |lane;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Execute-to-MEM bundle and the registered writeback bundle leaving MEM.
// master = execute/writeback side, slave = the MEM stage.
`ifndef DWIDTH
`define DWIDTH 32
`endif
`ifndef AWIDTH
`define AWIDTH 5
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 6
`endif

interface memory_stage_if;
  logic                     ms_i_ce;
  logic [`OPCODE_WIDTH-1:0] ms_i_opcode;
  logic [`DWIDTH-1:0]       ms_i_alu_value;
  logic [`DWIDTH-1:0]       ms_i_data_rt;
  logic                     ms_i_memwrite;
  logic                     ms_i_memtoreg;
  logic                     ms_i_reg_wr;
  logic [`AWIDTH-1:0]       ms_i_addr_rd;

  logic                     ms_o_ce;
  logic [`DWIDTH-1:0]       ms_o_data_rd;
  logic [`AWIDTH-1:0]       ms_o_addr_rd;
  logic                     ms_o_reg_wr;
  logic                     ms_o_misalign;

  modport master (
    output ms_i_ce, ms_i_opcode, ms_i_alu_value, ms_i_data_rt,
           ms_i_memwrite, ms_i_memtoreg, ms_i_reg_wr, ms_i_addr_rd,
    input  ms_o_ce, ms_o_data_rd, ms_o_addr_rd, ms_o_reg_wr, ms_o_misalign
  );

  modport slave (
    input  ms_i_ce, ms_i_opcode, ms_i_alu_value, ms_i_data_rt,
           ms_i_memwrite, ms_i_memtoreg, ms_i_reg_wr, ms_i_addr_rd,
    output ms_o_ce, ms_o_data_rd, ms_o_addr_rd, ms_o_reg_wr, ms_o_misalign
  );
endinterface

// File: rtl/memory_stage_dmem.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Read is read-before-write: a read and write on the same edge return the old word.
module memory_stage_dmem
  import memory_stage_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [3:0]           be_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [DWIDTH-1:0]    wdata_i,
  output logic [DWIDTH-1:0]    rdata_o
);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rdata_q;

  // Byte-lane writes; unselected lanes keep their contents.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Registered read; holds its last value when no read is requested.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_stage.sv
// MIPS MEM stage: alignment check, store lane steering, data memory access,
// load extract/extend and the one-cycle writeback register.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = 10
) (
  input  logic           ms_clk,
  input  logic           ms_rst,
  memory_stage_if.slave  ms_bus
);

  logic [1:0]           lane;
  logic [ADDR_BITS-1:0] widx;
  size_e                size;
  logic                 mem_acc;
  logic                 mis;
  logic                 wr_en;
  logic                 rd_en;
  logic [3:0]           be;
  logic [DWIDTH-1:0]    wdata;
  logic [DWIDTH-1:0]    rdata;

  logic                 ce_d,     ce_q;
  logic                 reg_wr_d, reg_wr_q;
  logic                 mis_d,    mis_q;
  logic [AWIDTH-1:0]    addr_d,   addr_q;
  logic [DWIDTH-1:0]    alu_d,    alu_q;
  logic                 load_d,   load_q;
  size_e                size_d,   size_q;
  logic [1:0]           lane_d,   lane_q;
  logic                 sgn_d,    sgn_q;

  logic [15:0]          lane_half;
  logic [DWIDTH-1:0]    load_data;

  assign lane    = ms_bus.ms_i_alu_value[1:0];
  assign widx    = ms_bus.ms_i_alu_value[ADDR_BITS+1:2];
  assign size    = access_size(ms_bus.ms_i_opcode);
  assign mem_acc = ms_bus.ms_i_memwrite | ms_bus.ms_i_memtoreg;
  assign mis     = ms_bus.ms_i_ce & mem_acc & is_misaligned(size, lane);

  // Reset is folded into the enables so a store sampled while reset is low is dropped.
  assign wr_en = ms_rst & ms_bus.ms_i_ce & ms_bus.ms_i_memwrite & ~mis;
  assign rd_en = ms_rst & ms_bus.ms_i_ce & ms_bus.ms_i_memtoreg;

  // Byte enables and store data replicated across lanes for the access size.
  always_comb begin
    be    = 4'b0000;
    wdata = ms_bus.ms_i_data_rt;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << lane;
        wdata = {4{ms_bus.ms_i_data_rt[7:0]}};
      end
      SZ_HALF: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{ms_bus.ms_i_data_rt[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = ms_bus.ms_i_data_rt;
      end
    endcase
  end

  memory_stage_dmem #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_dmem (
    .clk_i   (ms_clk),
    .we_i    (wr_en),
    .re_i    (rd_en),
    .be_i    (be),
    .addr_i  (widx),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );

  // Next-state for the writeback register; payload holds while the input is idle.
  always_comb begin
    ce_d     = ms_bus.ms_i_ce;
    reg_wr_d = ms_bus.ms_i_ce & ms_bus.ms_i_reg_wr & ~ms_bus.ms_i_memwrite & ~mis;
    mis_d    = mis;
    addr_d   = addr_q;
    alu_d    = alu_q;
    load_d   = load_q;
    size_d   = size_q;
    lane_d   = lane_q;
    sgn_d    = sgn_q;
    if (ms_bus.ms_i_ce) begin
      addr_d = ms_bus.ms_i_addr_rd;
      alu_d  = ms_bus.ms_i_alu_value;
      load_d = ms_bus.ms_i_memtoreg;
      size_d = size;
      lane_d = lane;
      sgn_d  = is_signed_load(ms_bus.ms_i_opcode);
    end
  end

  // Writeback register with asynchronous clear.
  always_ff @(posedge ms_clk or negedge ms_rst) begin
    if (!ms_rst) begin
      ce_q     <= 1'b0;
      reg_wr_q <= 1'b0;
      mis_q    <= 1'b0;
      addr_q   <= '0;
      alu_q    <= '0;
      load_q   <= 1'b0;
      size_q   <= SZ_WORD;
      lane_q   <= 2'b00;
      sgn_q    <= 1'b0;
    end else begin
      ce_q     <= ce_d;
      reg_wr_q <= reg_wr_d;
      mis_q    <= mis_d;
      addr_q   <= addr_d;
      alu_q    <= alu_d;
      load_q   <= load_d;
      size_q   <= size_d;
      lane_q   <= lane_d;
      sgn_q    <= sgn_d;
    end
  end

  // Lane extract and sign/zero extension applied to the registered RAM word.
  always_comb begin
    lane_half = 16'(rdata >> {lane_q, 3'b000});
    load_data = rdata;
    case (size_q)
      SZ_BYTE: load_data = sgn_q ? {{(DWIDTH-8){lane_half[7]}}, lane_half[7:0]}
                                 : {{(DWIDTH-8){1'b0}}, lane_half[7:0]};
      SZ_HALF: load_data = sgn_q ? {{(DWIDTH-16){lane_half[15]}}, lane_half}
                                 : {{(DWIDTH-16){1'b0}}, lane_half};
      default: load_data = rdata;
    endcase
  end

  assign ms_bus.ms_o_ce        = ce_q;
  assign ms_bus.ms_o_reg_wr    = reg_wr_q;
  assign ms_bus.ms_o_misalign  = mis_q;
  assign ms_bus.ms_o_addr_rd   = addr_q;
  assign ms_bus.ms_o_data_rd   = load_q ? load_data : alu_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: loads, stores, lane handling, wrap, misalignment, reset.
`ifndef DWIDTH
`define DWIDTH 32
`endif
`ifndef AWIDTH
`define AWIDTH 5
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 6
`endif

module tb_memory_stage;

  logic ms_clk = 1'b0;
  logic ms_rst = 1'b0;
  int   tests_run = 0;
  int   fails = 0;

  memory_stage_if bus ();

  memory_stage #(.DEPTH(1024), .ADDR_BITS(10)) dut (
    .ms_clk (ms_clk),
    .ms_rst (ms_rst),
    .ms_bus (bus.slave)
  );

  always #5 ms_clk = ~ms_clk;

  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24,
                         LHU = 6'h25, SB = 6'h28, SH = 6'h29, SW = 6'h2B;

  task automatic drive(input logic ce, input logic [5:0] op, input logic [31:0] alu,
                       input logic [31:0] rt, input logic mw, input logic mtr,
                       input logic rw, input logic [4:0] rd);
    bus.ms_i_ce        = ce;
    bus.ms_i_opcode    = op;
    bus.ms_i_alu_value = alu;
    bus.ms_i_data_rt   = rt;
    bus.ms_i_memwrite  = mw;
    bus.ms_i_memtoreg  = mtr;
    bus.ms_i_reg_wr    = rw;
    bus.ms_i_addr_rd   = rd;
  endtask

  task automatic step;
    @(posedge ms_clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b1, 6'($urandom), $urandom, $urandom, 1'b0, 1'b0, 1'b1, 5'($urandom));
    step();
    tests_run++; if (bus.ms_o_ce !== 1'b0) begin fails++; $display("FAIL rst_ce: got %b expected 0", bus.ms_o_ce); end
    tests_run++; if (bus.ms_o_data_rd !== 32'h0) begin fails++; $display("FAIL rst_data: got %h expected 0", bus.ms_o_data_rd); end
    tests_run++; if (bus.ms_o_addr_rd !== 5'h0) begin fails++; $display("FAIL rst_addr: got %h expected 0", bus.ms_o_addr_rd); end
    tests_run++; if (bus.ms_o_reg_wr !== 1'b0) begin fails++; $display("FAIL rst_reg_wr: got %b expected 0", bus.ms_o_reg_wr); end
    tests_run++; if (bus.ms_o_misalign !== 1'b0) begin fails++; $display("FAIL rst_misalign: got %b expected 0", bus.ms_o_misalign); end
    @(negedge ms_clk);
    ms_rst = 1'b1;
    drive(1'b0, 6'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'h0);
    step();
    tests_run++; if (bus.ms_o_ce !== 1'b0) begin fails++; $display("FAIL idle_after_rst_ce: got %b expected 0", bus.ms_o_ce); end
  endtask

  task automatic test_store_load;
    drive(1'b1, SW, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 5'd3);
    step();
    tests_run++; if (bus.ms_o_reg_wr !== 1'b0) begin fails++; $display("FAIL sw_reg_wr: got %b expected 0", bus.ms_o_reg_wr); end
    tests_run++; if (bus.ms_o_ce !== 1'b1) begin fails++; $display("FAIL sw_ce: got %b expected 1", bus.ms_o_ce); end
    drive(1'b1, LW, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 5'd5);
    step();
    tests_run++; if (bus.ms_o_data_rd !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_data: got %h expected deadbeef", bus.ms_o_data_rd); end
    tests_run++; if (bus.ms_o_addr_rd !== 5'd5) begin fails++; $display("FAIL lw_addr: got %0d expected 5", bus.ms_o_addr_rd); end
    tests_run++; if (bus.ms_o_reg_wr !== 1'b1) begin fails++; $display("FAIL lw_reg_wr: got %b expected 1", bus.ms_o_reg_wr); end
    tests_run++; if (bus.ms_o_ce !== 1'b1) begin fails++; $display("FAIL lw_ce: got %b expected 1", bus.ms_o_ce); end
  endtask

  task automatic test_subword_loads;
    logic [5:0]  ops [5] = '{LB, LBU, LH, LHU, LB};
    logic [31:0] adr [5] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
    logic [31:0] exp [5] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD, 32'hFFFFFFEF};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ops[i], adr[i], 32'h0, 1'b0, 1'b1, 1'b1, 5'(i + 10));
      step();
      tests_run++; if (bus.ms_o_data_rd !== exp[i]) begin fails++; $display("FAIL subword_%0d: got %h expected %h", i, bus.ms_o_data_rd, exp[i]); end
    end
  endtask

  task automatic test_partial_store;
    drive(1'b1, SB, 32'h11, 32'h123456AA, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    drive(1'b1, SH, 32'h12, 32'hCAFE7777, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    drive(1'b1, LW, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 5'd6);
    step();
    tests_run++; if (bus.ms_o_data_rd !== 32'h7777AAEF) begin fails++; $display("FAIL partial_store: got %h expected 7777aaef", bus.ms_o_data_rd); end
  endtask

  task automatic test_passthrough;
    drive(1'b1, 6'h00, 32'h00001234, 32'h55555555, 1'b0, 1'b0, 1'b1, 5'd9);
    step();
    tests_run++; if (bus.ms_o_data_rd !== 32'h00001234) begin fails++; $display("FAIL pass_data: got %h expected 00001234", bus.ms_o_data_rd); end
    tests_run++; if (bus.ms_o_addr_rd !== 5'd9) begin fails++; $display("FAIL pass_addr: got %0d expected 9", bus.ms_o_addr_rd); end
    tests_run++; if (bus.ms_o_reg_wr !== 1'b1) begin fails++; $display("FAIL pass_reg_wr: got %b expected 1", bus.ms_o_reg_wr); end
    drive(1'b0, LW, 32'hABCD0000, 32'h0, 1'b0, 1'b1, 1'b1, 5'd17);
    step();
    tests_run++; if (bus.ms_o_ce !== 1'b0) begin fails++; $display("FAIL idle_ce: got %b expected 0", bus.ms_o_ce); end
    tests_run++; if (bus.ms_o_reg_wr !== 1'b0) begin fails++; $display("FAIL idle_reg_wr: got %b expected 0", bus.ms_o_reg_wr); end
    tests_run++; if (bus.ms_o_data_rd !== 32'h00001234) begin fails++; $display("FAIL idle_hold_data: got %h expected 00001234", bus.ms_o_data_rd); end
    tests_run++; if (bus.ms_o_addr_rd !== 5'd9) begin fails++; $display("FAIL idle_hold_addr: got %0d expected 9", bus.ms_o_addr_rd); end
  endtask

  task automatic test_wrap;
    drive(1'b1, SW, 32'h1000, 32'h0BADF00D, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    drive(1'b1, LW, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd4);
    step();
    tests_run++; if (bus.ms_o_data_rd !== 32'h0BADF00D) begin fails++; $display("FAIL wrap: got %h expected 0badf00d", bus.ms_o_data_rd); end
  endtask

  task automatic test_misalign;
    drive(1'b1, LW, 32'h12, 32'h0, 1'b0, 1'b1, 1'b1, 5'd12);
    step();
    tests_run++; if (bus.ms_o_misalign !== 1'b1) begin fails++; $display("FAIL mis_lw_flag: got %b expected 1", bus.ms_o_misalign); end
    tests_run++; if (bus.ms_o_reg_wr !== 1'b0) begin fails++; $display("FAIL mis_lw_reg_wr: got %b expected 0", bus.ms_o_reg_wr); end
    tests_run++; if (bus.ms_o_ce !== 1'b1) begin fails++; $display("FAIL mis_lw_ce: got %b expected 1", bus.ms_o_ce); end
    tests_run++; if (bus.ms_o_addr_rd !== 5'd12) begin fails++; $display("FAIL mis_lw_addr: got %0d expected 12", bus.ms_o_addr_rd); end
    drive(1'b1, SW, 32'h11, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    tests_run++; if (bus.ms_o_misalign !== 1'b1) begin fails++; $display("FAIL mis_sw_flag: got %b expected 1", bus.ms_o_misalign); end
    drive(1'b1, LW, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 5'd13);
    step();
    tests_run++; if (bus.ms_o_misalign !== 1'b0) begin fails++; $display("FAIL mis_one_cycle: got %b expected 0", bus.ms_o_misalign); end
    tests_run++; if (bus.ms_o_data_rd !== 32'h7777AAEF) begin fails++; $display("FAIL mis_sw_suppressed: got %h expected 7777aaef", bus.ms_o_data_rd); end
    drive(1'b1, LH, 32'h11, 32'h0, 1'b0, 1'b1, 1'b1, 5'd14);
    step();
    tests_run++; if (bus.ms_o_misalign !== 1'b1) begin fails++; $display("FAIL mis_lh_flag: got %b expected 1", bus.ms_o_misalign); end
  endtask

  task automatic test_reset_store;
    drive(1'b1, SW, 32'h20, 32'h11111111, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    @(negedge ms_clk);
    ms_rst = 1'b0;
    drive(1'b1, SW, 32'h20, 32'h22222222, 1'b1, 1'b0, 1'b0, 5'd0);
    #1;
    tests_run++; if (bus.ms_o_ce !== 1'b0) begin fails++; $display("FAIL async_rst_ce: got %b expected 0", bus.ms_o_ce); end
    step();
    @(negedge ms_clk);
    ms_rst = 1'b1;
    drive(1'b1, LW, 32'h20, 32'h0, 1'b0, 1'b1, 1'b1, 5'd7);
    step();
    tests_run++; if (bus.ms_o_data_rd !== 32'h11111111) begin fails++; $display("FAIL rst_store_dropped: got %h expected 11111111", bus.ms_o_data_rd); end
  endtask

  task automatic test_unknown_opcode;
    drive(1'b1, 6'h3F, 32'h20, 32'h0, 1'b0, 1'b1, 1'b1, 5'd8);
    step();
    tests_run++; if (bus.ms_o_data_rd !== 32'h11111111) begin fails++; $display("FAIL unk_word_data: got %h expected 11111111", bus.ms_o_data_rd); end
    tests_run++; if (bus.ms_o_reg_wr !== 1'b1) begin fails++; $display("FAIL unk_word_reg_wr: got %b expected 1", bus.ms_o_reg_wr); end
    drive(1'b1, 6'h3F, 32'h22, 32'h0, 1'b0, 1'b1, 1'b1, 5'd8);
    step();
    tests_run++; if (bus.ms_o_misalign !== 1'b1) begin fails++; $display("FAIL unk_word_mis: got %b expected 1", bus.ms_o_misalign); end
  endtask

  initial begin
    drive(1'b0, 6'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'h0);
    test_reset();
    test_store_load();
    test_subword_loads();
    test_partial_store();
    test_passthrough();
    test_wrap();
    test_misalign();
    test_reset_store();
    test_unknown_opcode();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
